// File: rtl/key_sample_debouncer.sv
// Debounces a raw active-low pushbutton and samples a raw switch on each accepted press,
// giving the serial detector one clean bit per press on the system clock.
module key_sample_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int PCNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_n,
  input  logic              sw_raw,
  output logic              key_level,
  output logic              key_press,
  output logic              key_release,
  output logic              bit_valid,
  output logic              bit_data,
  output logic [PCNT_W-1:0] press_count
);

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  // The counter holds how many consecutive stable samples have been seen, so the
  // sample that opens a wait state already counts as the first one.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [1:0]       key_sync;
  logic [1:0]       sw_sync;
  logic             key_s;
  logic             sw_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_sync <= 2'b11;
      sw_sync  <= 2'b00;
    end else begin
      key_sync <= {key_sync[0], key_n};
      sw_sync  <= {sw_sync[0], sw_raw};
    end
  end

  assign key_s = ~key_sync[1];
  assign sw_s  = sw_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RELEASED;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      bit_valid   <= 1'b0;
      bit_data    <= 1'b0;
      press_count <= '0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      bit_valid   <= 1'b0;
      case (state)
        RELEASED: begin
          cnt <= '0;
          if (key_s) begin
            state <= WAIT_PRESS;
            cnt   <= ONE;
          end
        end
        WAIT_PRESS: begin
          if (!key_s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            key_level   <= 1'b1;
            key_press   <= 1'b1;
            bit_valid   <= 1'b1;
            bit_data    <= sw_s;
            press_count <= press_count + PCNT_W'(1);
          end else begin
            cnt <= cnt + ONE;
          end
        end
        PRESSED: begin
          cnt <= '0;
          if (!key_s) begin
            state <= WAIT_RELEASE;
            cnt   <= ONE;
          end
        end
        WAIT_RELEASE: begin
          if (key_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state       <= RELEASED;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_sample_debouncer.sv
// Randomized scoreboard bench for key_sample_debouncer: a run-length model of the
// debounce rule predicts each press/release; a monitor pops predictions as pulses appear.
module tb_key_sample_debouncer;

  localparam int D  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_n;
  logic          sw_raw;
  logic          key_level;
  logic          key_press;
  logic          key_release;
  logic          bit_valid;
  logic          bit_data;
  logic [PW-1:0] press_count;

  key_sample_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .PCNT_W         (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .sw_raw     (sw_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          bd;
    logic [PW-1:0] pc;
  } press_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  press_t press_q[$];
  int     rel_pending = 0;
  int     valid_seen = 0;
  int     rel_seen = 0;
  int     last_press_cyc = -1;

  logic   ms1, ms2, ws1, ws2, m_ks, m_ss, lvl, bd;
  int     run, pc;
  press_t push_e, mon_e;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference: the debounced level flips once D consecutive synchronized samples disagree with it.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms1 = 1'b0; ms2 = 1'b0; ws1 = 1'b0; ws2 = 1'b0;
      lvl = 1'b0; bd = 1'b0; run = 0; pc = 0;
      press_q.delete();
      rel_pending = 0;
    end else begin
      m_ks = ms2;
      m_ss = ws2;
      ms2 = ms1;
      ms1 = ~key_n;
      ws2 = ws1;
      ws1 = sw_raw;
      if (m_ks != lvl) run++;
      else run = 0;
      if (run == D) begin
        run = 0;
        lvl = m_ks;
        if (lvl) begin
          pc = (pc + 1) % (1 << PW);
          bd = m_ss;
          push_e.bd = bd;
          push_e.pc = PW'(pc);
          press_q.push_back(push_e);
        end else begin
          rel_pending++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_output("reset_outputs",
                   int'({key_level, key_press, key_release, bit_valid, bit_data, press_count}), 0);
    end else begin
      check_output("key_level", key_level, lvl);
      check_output("valid_eq_press", bit_valid, key_press);
      check_output("press_release_excl", key_press & key_release, 0);
      check_output("bit_data_hold", bit_data, bd);
      check_output("press_count_now", press_count, pc);
      if (press_q.size() > 0) begin
        mon_e = press_q.pop_front();
        check_output("bit_valid", bit_valid, 1);
        check_output("bit_data", bit_data, mon_e.bd);
        check_output("press_count", press_count, mon_e.pc);
      end else begin
        check_output("spurious_press", bit_valid, 0);
      end
      if (rel_pending > 0) begin
        rel_pending--;
        check_output("key_release", key_release, 1);
      end else begin
        check_output("spurious_release", key_release, 0);
      end
      if (bit_valid) begin
        valid_seen++;
        last_press_cyc = cyc;
      end
      if (key_release) rel_seen++;
    end
  end

  task automatic apply_stimulus(input logic k, input logic s, input int n);
    key_n  = k;
    sw_raw = s;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int v0, r0, t0;
    logic s;
    rst    = 1'b0;
    key_n  = 1'b0;
    sw_raw = 1'b1;
    @(negedge clk);
    #1;
    apply_stimulus(1'b0, 1'b1, 3);
    check_output("s1_reset_zero",
                 int'({key_level, key_press, key_release, bit_valid, bit_data, press_count}), 0);

    key_n = 1'b1;
    rst   = 1'b1;
    v0 = valid_seen;
    r0 = rel_seen;
    apply_stimulus(1'b1, 1'b1, 20);
    check_output("s1_no_press", valid_seen - v0, 0);
    check_output("s1_no_release", rel_seen - r0, 0);
    check_output("s1_count", press_count, 0);

    // Key drops right after edge t0; the press pulse follows edge t0+2+D.
    t0 = cyc;
    v0 = valid_seen;
    apply_stimulus(1'b0, 1'b1, 30);
    check_output("s2_latency", last_press_cyc, t0 + 2 + D);
    check_output("s2_one_pulse", valid_seen - v0, 1);
    check_output("s2_bit_data", bit_data, 1);
    check_output("s2_level", key_level, 1);
    check_output("s2_count", press_count, 1);

    apply_stimulus(1'b0, 1'b0, 3);
    r0 = rel_seen;
    apply_stimulus(1'b1, 1'b0, 10);
    check_output("s4_one_release", rel_seen - r0, 1);
    check_output("s4_level", key_level, 0);
    check_output("s4_data_held", bit_data, 1);
    apply_stimulus(1'b0, 1'b0, 10);
    check_output("s4_new_data", bit_data, 0);
    check_output("s4_count", press_count, 2);
    apply_stimulus(1'b1, 1'b0, 10);

    v0 = valid_seen;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b1, 2);
      apply_stimulus(1'b1, 1'b1, 2);
    end
    apply_stimulus(1'b1, 1'b1, 10);
    check_output("s3_no_press", valid_seen - v0, 0);
    check_output("s3_level", key_level, 0);
    check_output("s3_count", press_count, 2);

    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0, 2);
    rst = 1'b1;
    v0 = valid_seen;
    for (int i = 0; i < 256; i++) begin
      s = 1'($urandom % 2);
      apply_stimulus(1'b0, s, 8);
      apply_stimulus(1'b1, s, 8);
    end
    check_output("s5_wrap_count", press_count, 0);
    check_output("s5_valid_pulses", valid_seen - v0, 256);

    v0 = valid_seen;
    apply_stimulus(1'b0, 1'b1, 3);
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b1, 1);
    check_output("s6_no_press_before", valid_seen - v0, 0);
    rst = 1'b1;
    t0 = cyc;
    apply_stimulus(1'b0, 1'b1, 12);
    check_output("s6_latency", last_press_cyc, t0 + 2 + D);
    check_output("s6_one_pulse", valid_seen - v0, 1);
    check_output("s6_count", press_count, 1);

    apply_stimulus(1'b1, 1'b0, 10);
    for (int i = 0; i < 80; i++) begin
      apply_stimulus(1'($urandom % 2), 1'($urandom % 2), 1 + int'($urandom % 9));
    end
    apply_stimulus(1'b1, 1'b0, 20);
    check_output("rand_press_drained", press_q.size(), 0);
    check_output("rand_release_drained", rel_pending, 0);
    check_output("rand_level_final", key_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
